// File: rtl/clock_divider_param_if.sv
// Ratio-load request and divided-rate strobe bundle for clock_divider_param.
// master drives reload requests and observes the strobe; slave is the divider itself.
interface clock_divider_param_if #(
  parameter int unsigned WIDTH = 2
);
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             enable;
  logic [WIDTH-1:0] count;

  modport master (
    output div_load,
    output div_value,
    input  enable,
    input  count
  );

  modport slave (
    input  div_load,
    input  div_value,
    output enable,
    output count
  );
endinterface

// File: rtl/clock_divider_param.sv
// One-cycle enable strobe every N clk cycles, registered, no input-to-output path, never stalls.
// CLOCK_DIVIDER_RUNTIME_EN compiles in runtime ratio reload via div_load/div_value.
module clock_divider_param #(
  parameter int unsigned DIVIDER = 2,
  parameter int unsigned WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  clock_divider_param_if.slave    bus
);

  localparam int unsigned      DIV_EFF  = (DIVIDER == 0) ? 1 : DIVIDER;
  localparam logic [WIDTH-1:0] LAST_RST = WIDTH'(DIV_EFF - 1);

  if ((64'd1 << WIDTH) < 64'(DIVIDER)) begin : g_width_check
    $error("clock_divider_param: 2**WIDTH must be >= DIVIDER");
  end

  // The ratio is kept as its terminal count N-1 so that N == 2**WIDTH still fits.
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] cnt_q;
  logic             en_q;

`ifdef CLOCK_DIVIDER_RUNTIME_EN
  logic [WIDTH-1:0] load_last;

  always_comb begin
    load_last = '0;
    if (bus.div_value != '0) begin
      load_last = bus.div_value - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last  <= LAST_RST;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (bus.div_load) begin
      // A load restarts the period and swallows any pulse due on this edge.
      last  <= load_last;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (cnt_q == last) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + WIDTH'(1);
      en_q  <= 1'b0;
    end
  end
`else
  logic unused_load_ports;

  assign last              = LAST_RST;
  assign unused_load_ports = &{1'b0, bus.div_load, bus.div_value};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (cnt_q == last) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + WIDTH'(1);
      en_q  <= 1'b0;
    end
  end
`endif

  assign bus.enable = en_q;
  assign bus.count  = cnt_q;

endmodule

// File: tb/tb_clock_divider_param.sv
// Directed bench for clock_divider_param: several fixed ratios plus the reload path.
// Expected count after k edges from a period start is k%N, with enable high when that is 0.
module tb_clock_divider_param;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  clock_divider_param_if #(.WIDTH(2)) i2 ();
  clock_divider_param_if #(.WIDTH(2)) i3 ();
  clock_divider_param_if #(.WIDTH(2)) i1 ();
  clock_divider_param_if #(.WIDTH(2)) i0 ();
  clock_divider_param_if #(.WIDTH(3)) ir ();

  clock_divider_param #(.DIVIDER(2), .WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(i2));
  clock_divider_param #(.DIVIDER(3), .WIDTH(2)) dut3 (.clk(clk), .reset(reset), .bus(i3));
  clock_divider_param #(.DIVIDER(1), .WIDTH(2)) dut1 (.clk(clk), .reset(reset), .bus(i1));
  clock_divider_param #(.DIVIDER(0), .WIDTH(2)) dut0 (.clk(clk), .reset(reset), .bus(i0));
  clock_divider_param #(.DIVIDER(2), .WIDTH(3)) dutr (.clk(clk), .reset(reset), .bus(ir));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors += 5;
    if (i2.count !== 2'd0 || i2.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div2: count=%0d enable=%b, want count=0 enable=0", i2.count, i2.enable);
    end
    if (i3.count !== 2'd0 || i3.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div3: count=%0d enable=%b, want count=0 enable=0", i3.count, i3.enable);
    end
    if (i1.count !== 2'd0 || i1.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div1: count=%0d enable=%b, want count=0 enable=0", i1.count, i1.enable);
    end
    if (i0.count !== 2'd0 || i0.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div0: count=%0d enable=%b, want count=0 enable=0", i0.count, i0.enable);
    end
    if (ir.count !== 3'd0 || ir.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_runtime: count=%0d enable=%b, want count=0 enable=0", ir.count, ir.enable);
    end
  endtask

  task automatic test_div2();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      vectors++;
      if (i2.count !== 2'(k % 2) || i2.enable !== ((k % 2) == 0)) begin
        miscompares++;
        $display("FAIL div2 edge %0d: count=%0d enable=%b, want count=%0d enable=%b",
                 k, i2.count, i2.enable, k % 2, (k % 2) == 0);
      end
    end
  endtask

  task automatic test_div3();
    int pulses = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (i3.enable === 1'b1) pulses++;
      vectors++;
      if (i3.count !== 2'(k % 3) || i3.enable !== ((k % 3) == 0)) begin
        miscompares++;
        $display("FAIL div3 edge %0d: count=%0d enable=%b, want count=%0d enable=%b",
                 k, i3.count, i3.enable, k % 3, (k % 3) == 0);
      end
    end
    vectors++;
    if (pulses !== 10) begin
      miscompares++;
      $display("FAIL div3_pulse_count: got %0d, want 10", pulses);
    end
  endtask

  task automatic test_div1_div0();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors += 2;
      if (i1.count !== 2'd0 || i1.enable !== 1'b1) begin
        miscompares++;
        $display("FAIL div1 edge %0d: count=%0d enable=%b, want count=0 enable=1", k, i1.count, i1.enable);
      end
      if (i0.count !== 2'd0 || i0.enable !== 1'b1) begin
        miscompares++;
        $display("FAIL div0 edge %0d: count=%0d enable=%b, want count=0 enable=1", k, i0.count, i0.enable);
      end
    end
  endtask

  task automatic test_reset_midperiod();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (i3.count !== 2'd1) begin
      miscompares++;
      $display("FAIL midreset_pre: count=%0d, want 1", i3.count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (i3.count !== 2'd0 || i3.enable !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_abort: count=%0d enable=%b, want count=0 enable=0", i3.count, i3.enable);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (i3.count !== 2'(k % 3) || i3.enable !== ((k % 3) == 0)) begin
        miscompares++;
        $display("FAIL midreset edge %0d: count=%0d enable=%b, want count=%0d enable=%b",
                 k, i3.count, i3.enable, k % 3, (k % 3) == 0);
      end
    end
  endtask

  // k counts edges since the current period began; per is the ratio in force.
  task automatic test_runtime_load();
    int k   = 0;
    int per = 2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < 44; s++) begin
      // Load on edges 5 (value 5) and 20 (value 0); reset+load together on edge 30.
      ir.div_load  = (s == 4 || s == 19 || s == 29);
      ir.div_value = (s == 4) ? 3'd5 : 3'd0;
      reset        = (s == 29);
      tick();
      ir.div_load = 1'b0;
      reset       = 1'b0;
      if (s == 29) begin
        k   = 0;
        per = 2;
      end else if (s == 4 || s == 19) begin
`ifdef CLOCK_DIVIDER_RUNTIME_EN
        k   = 0;
        per = (s == 4) ? 5 : 1;
`else
        k++;
`endif
      end else begin
        k++;
      end
      vectors++;
      if (ir.count !== 3'(k % per) || ir.enable !== (k != 0 && (k % per) == 0)) begin
        miscompares++;
        $display("FAIL runtime step %0d: count=%0d enable=%b, want count=%0d enable=%b",
                 s, ir.count, ir.enable, k % per, k != 0 && (k % per) == 0);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    i2.div_load = 1'b0; i2.div_value = '0;
    i3.div_load = 1'b0; i3.div_value = '0;
    i1.div_load = 1'b0; i1.div_value = '0;
    i0.div_load = 1'b0; i0.div_value = '0;
    ir.div_load = 1'b0; ir.div_value = '0;

    test_reset();
    test_div2();
    test_div3();
    test_div1_div0();
    test_reset_midperiod();
    test_runtime_load();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
